// File: rtl/vga_pkg.sv
// Shared VGA timing constants, scheduler state encoding and
// the default colour code driven after reset.
package vga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_SPLIT   = 400;
  localparam int H_TOTAL   = 1040;
  localparam int HS_START  = 856;
  localparam int HS_END    = 975;

  localparam int V_VISIBLE = 600;
  localparam int V_TOTAL   = 666;
  localparam int VS_START  = 637;
  localparam int VS_END    = 642;

  localparam int FRAME_CLK = H_TOTAL * V_TOTAL;

  localparam logic [23:0] DEF_RESET_CODE = 24'h000_000;

  typedef enum logic {
    IDLE,
    WAIT_VS
  } sched_state_t;

endpackage

// File: rtl/vga_code_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr
// wins; returns a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  // rotating priority search starting at ptr
  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vga_code_sched.sv
// Frame-synchronous colour-code scheduler: accepts one update at a
// time from round-robin requesters and commits it on vsync rise.
module vga_code_sched
  import vga_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                CODE_W     = 24,
  parameter logic [CODE_W-1:0] RESET_CODE = DEF_RESET_CODE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      vsync,
  output logic [CODE_W-1:0]         code,
  output logic                      pending,
  output logic                      commit,
  output logic [15:0]               frame_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t        r_state;
  sched_state_t        w_state_nx;
  logic [IW-1:0]       r_rr_ptr;
  logic [CODE_W-1:0]   r_pend;
  logic [CODE_W-1:0]   r_code;
  logic                r_commit;
  logic                r_vsync_q;
  logic [15:0]         r_frame_cnt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_ready;
  logic [IW-1:0]       w_idx;
  logic                w_vs_rise;
  logic                w_xfer;
  logic                w_load;
  logic [CODE_W-1:0]   w_sel_code;
  logic [IW-1:0]       w_ptr_nx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign w_vs_rise  = vsync & ~r_vsync_q;
  assign w_sel_code = req_code[w_idx*CODE_W +: CODE_W];
  assign w_ptr_nx   = (w_idx == IW'(NUM_REQ - 1))
                    ? '0 : w_idx + IW'(1);

  // next state, grant gating and transfer/commit strobes
  always_comb begin
    w_state_nx = r_state;
    w_ready    = '0;
    w_xfer     = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = rst_n ? w_grant : '0;
        if (|w_grant) begin
          w_xfer     = 1'b1;
          w_state_nx = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (w_vs_rise) begin
          w_load     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // pending capture, pointer advance and code commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= RESET_CODE;
      r_rr_ptr <= '0;
      r_code   <= RESET_CODE;
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_load;
      if (w_xfer) begin
        r_pend   <= w_sel_code;
        r_rr_ptr <= w_ptr_nx;
      end
      if (w_load) r_code <= r_pend;
    end
  end

  // vsync edge detector and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= vsync;
      if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign req_ready = w_ready;
  assign code      = r_code;
  assign pending   = (r_state == WAIT_VS);
  assign commit    = r_commit;
  assign frame_cnt = r_frame_cnt;

endmodule
